// File: rtl/rx_crc_par_pkg.sv
// Shared constants and FSM encoding for the parallel receive-side CRC checker.
package rx_crc_par_pkg;

   localparam int          CRC_W_DEF  = 10;
   localparam int          DATA_W_DEF = 54;
   localparam logic [9:0]  POLY_DEF   = 10'h233;
   localparam int          BPC_DEF    = 4;
   localparam int          CNT_W      = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/crc_step_comb.sv
// Combinational advance of the division remainder by BPC frame bits, MSB first.
module crc_step_comb
   import rx_crc_par_pkg::*;
#(
   parameter int               CRC_W = CRC_W_DEF,
   parameter logic [CRC_W-1:0] POLY  = CRC_W'(POLY_DEF),
   parameter int               BPC   = BPC_DEF
) (
   input  logic [CRC_W-1:0] rem_in,
   input  logic [BPC-1:0]   bits_in,
   output logic [CRC_W-1:0] rem_out
);

   logic [CRC_W-1:0] chain [BPC+1];

   assign chain[0] = rem_in;

   // Each stage shifts one bit into the remainder and subtracts the divisor
   // whenever the bit falling off the top (the x^CRC_W term) is set.
   for (genvar gi = 0; gi < BPC; gi++) begin : g_stage
      assign chain[gi+1] = {chain[gi][CRC_W-2:0], bits_in[BPC-1-gi]}
                         ^ ({CRC_W{chain[gi][CRC_W-1]}} & POLY);
   end

   assign rem_out = chain[BPC];

endmodule

// File: rtl/rx_crc_par.sv
// Receive CRC checker: divides a whole frame by {1,POLY}, BPC bits per clock,
// and reports the remainder with a valid/ready handshake plus saturating stats.
module rx_crc_par
   import rx_crc_par_pkg::*;
#(
   parameter int               CRC_W  = CRC_W_DEF,
   parameter int               DATA_W = DATA_W_DEF,
   parameter logic [CRC_W-1:0] POLY   = CRC_W'(POLY_DEF),
   parameter int               BPC    = BPC_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    in_vld,
   output logic                    in_rdy,
   input  logic [CRC_W+DATA_W-1:0] in_data,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic [CRC_W-1:0]        out_rem,
   output logic                    out_err,
   output logic [CNT_W-1:0]        frm_cnt,
   output logic [CNT_W-1:0]        err_cnt,
   input  logic                    stat_clr
);

   localparam int FRAME_W = CRC_W + DATA_W;
   localparam int N_BEATS = FRAME_W / BPC;
   localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

   if ((BPC < 1) || (BPC > FRAME_W) || ((FRAME_W % BPC) != 0)) begin : g_param_check
      $error("rx_crc_par: BPC=%0d must divide CRC_W+DATA_W=%0d", BPC, FRAME_W);
   end

   state_t               state_reg;
   state_t               state_next;
   logic [FRAME_W-1:0]   frame_reg;
   logic [CRC_W-1:0]     rem_reg;
   logic [CRC_W-1:0]     rem_step;
   logic [BEAT_W-1:0]    beat_reg;
   logic                 out_vld_reg;
   logic [CRC_W-1:0]     out_rem_reg;
   logic                 out_err_reg;
   logic [CNT_W-1:0]     frm_cnt_reg;
   logic [CNT_W-1:0]     err_cnt_reg;
   logic                 last_beat;
   logic                 done_hs;

   crc_step_comb #(
      .CRC_W (CRC_W),
      .POLY  (POLY),
      .BPC   (BPC)
   ) u_step (
      .rem_in  (rem_reg),
      .bits_in (frame_reg[FRAME_W-1 -: BPC]),
      .rem_out (rem_step)
   );

   assign last_beat = (beat_reg == BEAT_W'(N_BEATS - 1));
   assign done_hs   = (state_reg == DONE) && out_vld_reg && out_rdy && !clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (clr) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (in_vld)                 state_next = CALC;
            CALC:    if (last_beat)              state_next = DONE;
            DONE:    if (out_vld_reg && out_rdy) state_next = IDLE;
            default:                             state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_reg   <= '0;
         rem_reg     <= '0;
         beat_reg    <= '0;
         out_vld_reg <= 1'b0;
         out_rem_reg <= '0;
         out_err_reg <= 1'b0;
      end else if (clr) begin
         out_vld_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_vld) begin
                  frame_reg <= in_data;
                  rem_reg   <= '0;
                  beat_reg  <= '0;
               end
            end
            CALC: begin
               frame_reg <= frame_reg << BPC;
               rem_reg   <= rem_step;
               beat_reg  <= beat_reg + 1'b1;
               // Result is captured straight from the last step so out_vld
               // rises on the same edge the FSM enters DONE.
               if (last_beat) begin
                  out_vld_reg <= 1'b1;
                  out_rem_reg <= rem_step;
                  out_err_reg <= |rem_step;
               end
            end
            DONE: begin
               if (out_rdy) begin
                  out_vld_reg <= 1'b0;
               end
            end
            default: begin
               out_vld_reg <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frm_cnt_reg <= '0;
         err_cnt_reg <= '0;
      end else if (stat_clr) begin
         frm_cnt_reg <= '0;
         err_cnt_reg <= '0;
      end else if (done_hs) begin
         frm_cnt_reg <= sat_inc(frm_cnt_reg);
         if (out_err_reg) begin
            err_cnt_reg <= sat_inc(err_cnt_reg);
         end
      end
   end

   assign in_rdy  = (state_reg == IDLE);
   assign out_vld = out_vld_reg;
   assign out_rem = out_rem_reg;
   assign out_err = out_err_reg;
   assign frm_cnt = frm_cnt_reg;
   assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_rx_crc_par.sv
// Scoreboard bench for rx_crc_par: one directed/random instance (BPC=4) plus a BPC sweep.
module tb_rx_crc_par;

   localparam int          CW   = 10;
   localparam int          DW   = 54;
   localparam int          FW   = CW + DW;
   localparam int          NI   = 5;
   localparam logic [CW-1:0] POLY = 10'h233;

   function automatic int bpc_of(input int k);
      case (k)
         0:       return 4;
         1:       return 1;
         2:       return 2;
         3:       return 8;
         default: return 16;
      endcase
   endfunction

   typedef struct {
      logic [CW-1:0] rem;
      int unsigned   acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          in_vld = 1'b0, clr = 1'b0, out_rdy = 1'b0, stat_clr = 1'b0, sw_vld = 1'b0;
   logic [FW-1:0] in_data = '0, sw_data = '0;
   logic          in_rdy_a  [NI];
   logic          out_vld_a [NI];
   logic          out_err_a [NI];
   logic [CW-1:0] out_rem_a [NI];
   logic [15:0]   frm_a     [NI];
   logic [15:0]   err_a     [NI];

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   checks = 0;
   int   errors = 0;
   logic done   = 1'b0;
   logic [15:0] m_frm = '0, m_err = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Textbook long division of the frame polynomial by x^CW + POLY.
   function automatic logic [CW-1:0] ref_rem(input logic [FW-1:0] f);
      logic [FW-1:0] r;
      logic [FW-1:0] g;
      r = f;
      g = FW'({1'b1, POLY});
      for (int i = FW - 1; i >= CW; i--) begin
         if (r[i]) r = r ^ (g << (i - CW));
      end
      return r[CW-1:0];
   endfunction

   function automatic logic [15:0] sat16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [FW-1:0] make_frame(input bit good);
      logic [FW-1:0] d;
      d = {$urandom, $urandom};
      if (good) begin
         d = {d[DW-1:0], {CW{1'b0}}};
         d[CW-1:0] = ref_rem(d);
      end
      return d;
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int BPC_I = bpc_of(gi);
      localparam int N_I   = FW / BPC_I;
      logic vld_i;
      logic clr_i;
      logic [FW-1:0] data_i;
      exp_t exp_q [$];

      assign vld_i  = (gi == 0) ? in_vld  : sw_vld;
      assign clr_i  = (gi == 0) ? clr     : 1'b0;
      assign data_i = (gi == 0) ? in_data : sw_data;

      rx_crc_par #(
         .CRC_W  (CW),
         .DATA_W (DW),
         .POLY   (POLY),
         .BPC    (BPC_I)
      ) dut (
         .clk      (clk),
         .rst      (rst),
         .clr      (clr_i),
         .in_vld   (vld_i),
         .in_rdy   (in_rdy_a[gi]),
         .in_data  (data_i),
         .out_vld  (out_vld_a[gi]),
         .out_rdy  ((gi == 0) ? out_rdy : 1'b1),
         .out_rem  (out_rem_a[gi]),
         .out_err  (out_err_a[gi]),
         .frm_cnt  (frm_a[gi]),
         .err_cnt  (err_a[gi]),
         .stat_clr ((gi == 0) ? stat_clr : 1'b0)
      );

      // Expected results enter the queue when a frame is accepted.
      initial forever begin
         exp_t e;
         @(posedge clk);
         if (rst || clr_i) begin
            exp_q.delete();
         end else if (vld_i && in_rdy_a[gi]) begin
            e.rem = ref_rem(data_i);
            e.acc = cyc;
            exp_q.push_back(e);
         end
      end

      initial begin
         bit            seen;
         logic [CW-1:0] held_rem;
         logic          held_err;
         exp_t          e;
         seen = 1'b0;
         forever begin
            @(negedge clk);
            if (out_vld_a[gi] && !rst) begin
               if (!seen) begin
                  seen     = 1'b1;
                  held_rem = out_rem_a[gi];
                  held_err = out_err_a[gi];
                  chk($sformatf("pending_exp%0d", gi), 64'(exp_q.size() > 0), 1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     $display("inst%0d bpc=%0d rem=%03h exp=%03h err=%0b", gi, BPC_I,
                              out_rem_a[gi], e.rem, out_err_a[gi]);
                     chk($sformatf("rem%0d", gi), out_rem_a[gi], e.rem);
                     chk($sformatf("err%0d", gi), out_err_a[gi], |e.rem);
                     chk($sformatf("latency%0d", gi), cyc - e.acc - 1, N_I);
                  end
               end else begin
                  chk($sformatf("hold_rem%0d", gi), out_rem_a[gi], held_rem);
                  chk($sformatf("hold_err%0d", gi), out_err_a[gi], held_err);
               end
            end else begin
               seen = 1'b0;
            end
         end
      end

      initial begin
         wait (done);
         chk($sformatf("leftover%0d", gi), exp_q.size(), 0);
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_rdy"},  in_rdy_a[0],  1);
      chk({tag, "_out_vld"}, out_vld_a[0], 0);
      chk({tag, "_out_rem"}, out_rem_a[0], 0);
      chk({tag, "_out_err"}, out_err_a[0], 0);
      chk({tag, "_frm_cnt"}, frm_a[0],     0);
      chk({tag, "_err_cnt"}, err_a[0],     0);
   endtask

   task automatic send(input logic [FW-1:0] d);
      int t;
      t = 0;
      while (!in_rdy_a[0] && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("send_rdy", in_rdy_a[0], 1);
      in_vld  = 1'b1;
      in_data = d;
      @(negedge clk);
      in_vld  = 1'b0;
      chk("busy_calc", in_rdy_a[0], 0);
   endtask

   task automatic finish_frame(input logic [FW-1:0] d, input int hold, input bit sc);
      int t;
      t = 0;
      while (!out_vld_a[0] && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("vld_wait", out_vld_a[0], 1);
      repeat (hold) begin
         in_vld  = 1'b1;
         in_data = make_frame(1'b0);
         chk("rdy_in_done", in_rdy_a[0], 0);
         @(negedge clk);
      end
      in_vld   = 1'b0;
      out_rdy  = 1'b1;
      stat_clr = sc;
      @(negedge clk);
      out_rdy  = 1'b0;
      stat_clr = 1'b0;
      if (sc) begin
         m_frm = '0;
         m_err = '0;
      end else begin
         m_frm = sat16(m_frm);
         if (ref_rem(d) != '0) m_err = sat16(m_err);
      end
      chk("vld_drop", out_vld_a[0], 0);
      chk("rdy_after", in_rdy_a[0], 1);
      chk("frm_cnt", frm_a[0], m_frm);
      chk("err_cnt", err_a[0], m_err);
   endtask

   task automatic frame(input logic [FW-1:0] d, input int hold, input bit sc);
      send(d);
      finish_frame(d, hold, sc);
   endtask

   initial begin
      logic [FW-1:0] d;
      int            t;
      bit            all_rdy;

      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst = 1'b0;
      @(negedge clk);

      frame(64'h0,   0, 1'b0);
      frame(64'h400, 0, 1'b0);
      frame(64'h633, 0, 1'b0);
      frame(64'h1,   0, 1'b0);
      frame(64'h400, 20, 1'b0);

      // Abort at CALC beat 7: nothing may come out, count unchanged.
      send(make_frame(1'b0));
      repeat (7) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_idle", in_rdy_a[0], 1);
      chk("clr_novld", out_vld_a[0], 0);
      repeat (20) @(negedge clk);
      chk("clr_frm", frm_a[0], m_frm);

      clr     = 1'b1;
      in_vld  = 1'b1;
      in_data = make_frame(1'b0);
      @(negedge clk);
      clr     = 1'b0;
      in_vld  = 1'b0;
      chk("clr_beats_vld", in_rdy_a[0], 1);

      // Asynchronous reset at beat 3 takes effect before the next edge.
      send(64'h1);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_reset_vals("async_rst");
      @(negedge clk);
      rst   = 1'b0;
      m_frm = '0;
      m_err = '0;
      @(negedge clk);

      frame(64'h1, 0, 1'b0);
      frame(64'h1, 2, 1'b1);

      for (int k = 0; k < 10; k++) begin
         d = make_frame(k[0]);
         frame(d, $urandom_range(3, 0), 1'b0);
      end

      force g_dut[0].dut.err_cnt_reg = 16'hFFFD;
      force g_dut[0].dut.frm_cnt_reg = 16'hFFFD;
      @(negedge clk);
      release g_dut[0].dut.err_cnt_reg;
      release g_dut[0].dut.frm_cnt_reg;
      m_err = 16'hFFFD;
      m_frm = 16'hFFFD;
      for (int k = 0; k < 4; k++) frame(64'h1, 0, 1'b0);

      for (int k = 0; k < 30; k++) begin
         t = 0;
         all_rdy = 1'b0;
         while (!all_rdy && t < 200) begin
            all_rdy = in_rdy_a[1] && in_rdy_a[2] && in_rdy_a[3] && in_rdy_a[4];
            if (!all_rdy) begin
               @(negedge clk);
               t++;
            end
         end
         chk("sweep_rdy", all_rdy, 1);
         sw_vld  = 1'b1;
         sw_data = make_frame(k[0]);
         @(negedge clk);
         sw_vld  = 1'b0;
      end
      repeat (80) @(negedge clk);

      done = 1'b1;
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
